// File: rtl/reg_bank_pkg.sv
// -----------------------------------------------------------------------------
// reg_bank_pkg
// Shared types and helpers for the register-bank arbiter:
//   state_t - controller FSM states (IDLE: arbitrate, COMMIT: write the bank)
//   idx_w() - index width for a count of items, never narrower than one bit
// -----------------------------------------------------------------------------
package reg_bank_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_bank_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. The search starts at last+1 and moves
// upward with wrap-around, so the most recently served requester has the
// lowest priority.
// Ports:
//   req  in  N_REQ  request vector
//   last in  IDX_W  index of the most recently served requester
//   gnt  out N_REQ  one-hot winner, all zero when no request is present
//   idx  out IDX_W  index of the winner (0 when none)
//   any  out 1      at least one request is present
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin : pick_c
    int cand;
    // NOTE: every output gets a default before the search; otherwise paths
    // that find no request would leave them unassigned and infer latches.
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = (int'(last) + i) % N_REQ;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// -----------------------------------------------------------------------------
// reg_bank_arbiter
// Shared register-bank controller. Up to N_REQ requesters compete for one
// DEPTH x WIDTH flip-flop bank. Each accepted write is a two-phase transfer:
// the handshake captures address/data/id into hold registers (IDLE), and the
// following cycle commits the hold data into the bank (COMMIT). At most one
// write is accepted every two cycles. The read port is purely combinational.
//
// Parameters: N_REQ (2..8), WIDTH, DEPTH (power of two)
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   req_valid  in   N_REQ         per-requester write request
//   req_addr   in   N_REQ*ADDR_W  requester i uses slice i
//   req_data   in   N_REQ*WIDTH   requester i uses slice i
//   req_ready  out  N_REQ         one-hot grant, only in IDLE
//   rd_addr    in   ADDR_W        read address
//   rd_data    out  WIDTH         combinational read of the bank
//   grant_id   out  ID_W          last accepted requester (registered)
//   busy       out  1             high while in COMMIT
//
// Build option: define REG_BANK_BYPASS_EN to forward the held write data to
// rd_data during COMMIT when rd_addr matches the pending write address.
// -----------------------------------------------------------------------------
module reg_bank_arbiter
  import reg_bank_pkg::*;
#(
  parameter  int N_REQ  = 4,
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = idx_w(DEPTH),
  localparam int ID_W   = idx_w(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*WIDTH-1:0]  req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [WIDTH-1:0]        rd_data,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy
);

  state_t            state;
  logic [ID_W-1:0]   last;
  logic [ID_W-1:0]   hold_id;
  logic [ADDR_W-1:0] hold_addr;
  logic [WIDTH-1:0]  hold_data;
  logic [WIDTH-1:0]  bank [DEPTH];

  logic [N_REQ-1:0]  pick_gnt;
  logic [ID_W-1:0]   pick_idx;
  logic              pick_any;
  logic [ADDR_W-1:0] pick_addr;
  logic [WIDTH-1:0]  pick_data;
  logic              handshake;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (ID_W)
  ) u_rr_pick (
    .req  (req_valid),
    .last (last),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Grants are offered only in IDLE and never while reset is asserted, so a
  // request seen in the reset cycle cannot complete a handshake.
  assign req_ready = (state == IDLE && !rst) ? pick_gnt : '0;
  assign handshake = (state == IDLE) && !rst && pick_any;
  assign pick_addr = req_addr[pick_idx*ADDR_W +: ADDR_W];
  assign pick_data = req_data[pick_idx*WIDTH +: WIDTH];
  assign busy      = (state == COMMIT);

`ifdef REG_BANK_BYPASS_EN
  assign rd_data = (state == COMMIT && rd_addr == hold_addr) ? hold_data
                                                             : bank[rd_addr];
`else
  assign rd_data = bank[rd_addr];
`endif

  // NOTE: all state here is sequential and uses non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      // NOTE: the bank is plain flops that must read as zero after reset (and
      // a reset mid-COMMIT must discard the pending write), so it is cleared
      // explicitly; this would not map onto a RAM macro.
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
      hold_id   <= '0;
      hold_addr <= '0;
      hold_data <= '0;
      // Start "last" at the top index so requester 0 wins first.
      last      <= ID_W'(N_REQ - 1);
      grant_id  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            hold_id   <= pick_idx;
            hold_addr <= pick_addr;
            hold_data <= pick_data;
            grant_id  <= pick_idx;
            state     <= COMMIT;
          end
        end
        COMMIT: begin
          bank[hold_addr] <= hold_data;
          // Priority rotates only once the write has been committed.
          last            <= hold_id;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
